// File: rtl/membus_pkg.sv
// Shared memory_bus types, defaults and sizing helpers for the bus initiator and its response FIFO.
package membus_pkg;

  localparam int unsigned MEMBUS_ADDR_WIDTH = 10;
  localparam int unsigned MEMBUS_DATA_WIDTH = 32;
  localparam int unsigned MEMBUS_RSP_DEPTH  = 2;

  typedef logic [MEMBUS_ADDR_WIDTH-1:0] addr_t;
  typedef logic [MEMBUS_DATA_WIDTH-1:0] data_t;

  // The two ends of memory_bus, matching the modport names in membus.sv
  typedef enum logic {
    MP_MEMORY     = 1'b0,
    MP_CONTROLLER = 1'b1
  } membus_modport_e;

  // Width of a counter that must hold 0..depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer indexing 0..depth-1 (at least one bit)
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/membus.sv
// memory_bus: single-port synchronous memory interface (1-cycle read latency, read-first).
interface memory_bus #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] address;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  modport memory (
    input  address,
    input  write_enable,
    input  write_data,
    output read_data
  );

  modport controller (
    output address,
    output write_enable,
    output write_data,
    input  read_data
  );

endinterface

// File: rtl/membus_initiator_resp_fifo.sv
// resp_fifo: circular sync FIFO with occupancy count and optional empty-fall-through of push data.
module resp_fifo
  import membus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEMBUS_DATA_WIDTH,
  parameter int unsigned DEPTH      = MEMBUS_RSP_DEPTH,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  empty;
  logic                  do_pop;

  // Explicit wrap so non power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign out_valid = !empty || (BYPASS && push);
  assign out_data  = (BYPASS && empty) ? push_data : mem[rd_ptr];
  assign do_pop    = pop && out_valid;

  // Storage is always written on push; a same-cycle bypass pop simply skips past it
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(DEPTH)));

endmodule

// File: rtl/membus_initiator.sv
// membus_initiator: valid/ready request stream to memory_bus cycles, read data returned in order
// through a credit-tracked response FIFO that absorbs the 1-cycle read latency and backpressure.
module membus_initiator
  import membus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEMBUS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEMBUS_DATA_WIDTH,
  parameter int unsigned RSP_DEPTH  = MEMBUS_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  memory_bus.controller         bus
);

  localparam int unsigned CW = cnt_width(RSP_DEPTH);

  logic                  fire;
  logic                  rd_fire;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] last_wdata;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         outstanding;

  // A read holds a credit from its fire until its response leaves the FIFO
  assign outstanding = fifo_count + CW'(inflight);
  assign req_ready   = (outstanding < CW'(RSP_DEPTH));
  assign fire        = req_valid && req_ready;
  assign rd_fire     = fire && !req_write;

  // Bus is driven straight from the request on fire, otherwise parked on the last values
  assign bus.address      = fire ? req_addr  : last_addr;
  assign bus.write_data   = fire ? req_wdata : last_wdata;
  assign bus.write_enable = fire && req_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      inflight <= rd_fire;
      if (fire) begin
        last_addr  <= req_addr;
        last_wdata <= req_wdata;
      end
    end
  end

  // Read data arrives the cycle after the read fire and is pushed unconditionally
  resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH),
    .BYPASS     (1'b1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.read_data),
    .pop       (rsp_ready),
    .out_valid (rsp_valid),
    .out_data  (rsp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_membus_initiator.sv
// Bench for membus_initiator with a behavioural read-first bram on memory_bus (4-bit addr, 8-bit data).
module tb_membus_initiator;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned RSP_DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  memory_bus #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  membus_initiator #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // bram: read-first, 1-cycle read latency
  logic [DW-1:0] bram_mem [16];
  always @(posedge clk) begin
    if (bus.write_enable) bram_mem[bus.address] <= bus.write_data;
    bus.read_data <= bram_mem[bus.address];
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: memory contents, queue of read results owed to the consumer
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;
  logic          held;
  logic [DW-1:0] held_data;
  logic          exp_ready;
  logic          exp_fire;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_last_addr  = '0;
      m_last_wdata = '0;
      held         = 1'b0;
    end else begin
      exp_ready = (exp_q.size() < RSP_DEPTH);
      check("mon_req_ready", req_ready, exp_ready);
      check("mon_rsp_valid", rsp_valid, exp_q.size() != 0);
      if (held) check("mon_rsp_hold", rsp_data, held_data);
      if (rsp_valid && rsp_ready && exp_q.size() != 0)
        check("mon_rsp_data", rsp_data, exp_q.pop_front());
      exp_fire = req_valid && exp_ready;
      check("mon_bus_we", bus.write_enable, exp_fire && req_write);
      check("mon_bus_addr", bus.address, exp_fire ? req_addr : m_last_addr);
      check("mon_bus_wdata", bus.write_data, exp_fire ? req_wdata : m_last_wdata);
      held      = rsp_valid && !rsp_ready;
      held_data = rsp_data;
      if (exp_fire) begin
        m_last_addr  = req_addr;
        m_last_wdata = req_wdata;
        if (req_write) ref_mem[req_addr] = req_wdata;
        else exp_q.push_back(ref_mem[req_addr]);
      end
    end
  end

  typedef struct {
    logic          v;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rr;
    logic          e_ready;
    logic          e_rvalid;
    logic [DW-1:0] e_rdata;
    logic          e_we;
    logic [AW-1:0] e_addr;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic v, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic rr, input logic er,
                              input logic ev, input logic [DW-1:0] ed, input logic ewe,
                              input logic [AW-1:0] ea);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.rr = rr;
    t.e_ready = er; t.e_rvalid = ev; t.e_rdata = ed; t.e_we = ewe; t.e_addr = ea;
    return t;
  endfunction

  function automatic logic [DW-1:0] pre(input int a);
    return (a == 3) ? 8'hA5 : 8'(a * 17 + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fires;
    int cyc;

    // single read of preloaded 0xA5
    vecs[0]  = mk(1, 0, 3, 8'h00, 1,  1, 0, 8'h00, 0, 3);
    vecs[1]  = mk(0, 0, 0, 8'h00, 1,  1, 1, 8'hA5, 0, 3);
    vecs[2]  = mk(0, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 3);
    // back-to-back reads 0..7, one response per cycle
    vecs[3]  = mk(1, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0);
    vecs[4]  = mk(1, 0, 1, 8'h00, 1,  1, 1, 8'h01, 0, 1);
    vecs[5]  = mk(1, 0, 2, 8'h00, 1,  1, 1, 8'h12, 0, 2);
    vecs[6]  = mk(1, 0, 3, 8'h00, 1,  1, 1, 8'h23, 0, 3);
    vecs[7]  = mk(1, 0, 4, 8'h00, 1,  1, 1, 8'hA5, 0, 4);
    vecs[8]  = mk(1, 0, 5, 8'h00, 1,  1, 1, 8'h45, 0, 5);
    vecs[9]  = mk(1, 0, 6, 8'h00, 1,  1, 1, 8'h56, 0, 6);
    vecs[10] = mk(1, 0, 7, 8'h00, 1,  1, 1, 8'h67, 0, 7);
    vecs[11] = mk(0, 0, 0, 8'h00, 1,  1, 1, 8'h78, 0, 7);
    vecs[12] = mk(0, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 7);
    // backpressure: credits run out after two reads
    vecs[13] = mk(1, 0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0);
    vecs[14] = mk(1, 0, 1, 8'h00, 0,  1, 1, 8'h01, 0, 1);
    vecs[15] = mk(1, 0, 2, 8'h00, 0,  0, 1, 8'h01, 0, 1);
    vecs[16] = mk(1, 0, 2, 8'h00, 0,  0, 1, 8'h01, 0, 1);
    vecs[17] = mk(1, 0, 2, 8'h00, 1,  0, 1, 8'h01, 0, 1);
    vecs[18] = mk(1, 0, 2, 8'h00, 1,  1, 1, 8'h12, 0, 2);
    vecs[19] = mk(0, 0, 0, 8'h00, 1,  1, 1, 8'h23, 0, 2);
    vecs[20] = mk(0, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 2);
    // write then read same address
    vecs[21] = mk(1, 1, 5, 8'h3C, 1,  1, 0, 8'h00, 1, 5);
    vecs[22] = mk(1, 0, 5, 8'h00, 1,  1, 0, 8'h00, 0, 5);
    vecs[23] = mk(0, 0, 0, 8'h00, 1,  1, 1, 8'h3C, 0, 5);
    vecs[24] = mk(0, 0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 5);

    rst = 1'b1; rsp_ready = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_bus_we", bus.write_enable, 1'b0);
    check("rst_bus_addr", bus.address, 4'h0);
    check("rst_bus_wdata", bus.write_data, 8'h00);
    step();

    // preload the whole bram through the initiator
    for (int a = 0; a < 16; a++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(a); req_wdata = pre(a);
      step();
    end
    idle_inputs();
    rsp_ready = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      req_valid = vecs[i].v; req_write = vecs[i].w; req_addr = vecs[i].a;
      req_wdata = vecs[i].d; rsp_ready = vecs[i].rr;
      @(negedge clk);
      check($sformatf("t%0d_req_ready", i), req_ready, vecs[i].e_ready);
      check($sformatf("t%0d_rsp_valid", i), rsp_valid, vecs[i].e_rvalid);
      check($sformatf("t%0d_bus_we", i), bus.write_enable, vecs[i].e_we);
      check($sformatf("t%0d_bus_addr", i), bus.address, vecs[i].e_addr);
      if (vecs[i].e_rvalid) check($sformatf("t%0d_rsp_data", i), rsp_data, vecs[i].e_rdata);
      step();
    end

    // random traffic against the reference model
    fires = 0;
    cyc = 0;
    while (fires < 500 && cyc < 4000) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_write = ($urandom_range(0, 3) == 0);
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (req_valid && req_ready) fires++;
      cyc++;
      step();
    end
    check("rand_ops_done", fires >= 500, 1'b1);
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (4) step();

    // read in flight when reset hits is dropped
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h2; rsp_ready = 1'b0;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst2_req_ready", req_ready, 1'b1);
    check("rst2_rsp_valid", rsp_valid, 1'b0);
    check("rst2_bus_we", bus.write_enable, 1'b0);
    check("rst2_bus_addr", bus.address, 4'h0);
    check("rst2_bus_wdata", bus.write_data, 8'h00);
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rst2_no_late_rsp", rsp_valid, 1'b0);
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
